// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - opcode enum and constants for acc_stack_unit
package acc_pkg;
    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        NOP  = 3'd0,
        LOAD = 3'd1,
        ADD  = 3'd2,
        SUB  = 3'd3,
        SHL  = 3'd4,
        SHR  = 3'd5,
        PUSH = 3'd6,
        POP  = 3'd7
    } acc_op_t;
endpackage

// File: rtl/acc_stack.sv
// rtl/acc_stack.sv - LIFO save/restore storage with depth counter, falling-edge clocked
module acc_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int DW    = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] top_data,
    output logic [DW-1:0]    depth,
    output logic             full,
    output logic             empty,
    output logic             err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;

    assign full     = (depth == DW'(DEPTH));
    assign empty    = (depth == '0);
    assign top_idx  = AW'(depth - DW'(1));
    assign wr_idx   = AW'(depth);
    assign top_data = mem[top_idx];

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            depth <= '0;
            err   <= 1'b0;
        end else begin
            err <= (push && full) || (pop && empty);
            if (push && !full)
                depth <= depth + DW'(1);
            else if (pop && !empty)
                depth <= depth - DW'(1);
        end
    end

    // Storage is not reset; a push coinciding with reset must not write.
    always_ff @(negedge clk) begin
        if (rst_n && push && !full)
            mem[wr_idx] <= wdata;
    end
endmodule

// File: rtl/acc_stack_unit.sv
// rtl/acc_stack_unit.sv - accumulator with source mux, flags and save stack; ACC_SAT_EN enables saturating ADD/SUB
module acc_stack_unit
    import acc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NSRC  = 4,
    parameter int DEPTH = 4,
    parameter int SW    = (NSRC > 1) ? $clog2(NSRC) : 1,
    parameter int DW    = $clog2(DEPTH+1)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [NSRC*WIDTH-1:0] src_in,
    input  logic [SW-1:0]         src_sel,
    input  logic [OP_W-1:0]       op,
    output logic [WIDTH-1:0]      acc_out,
    output logic                  carry_out,
    output logic                  zero_out,
    output logic [DW-1:0]         depth_out,
    output logic                  err_out
);
    acc_op_t          op_e;
    logic [WIDTH-1:0] src;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] next_acc;
    logic             next_carry;
    logic [WIDTH-1:0] stack_top;
    logic             stack_full;
    logic             stack_empty;

    assign op_e = acc_op_t'(op);

    // Unmatched selects (>= NSRC) fall back to source 0.
    always_comb begin
        src = src_in[0 +: WIDTH];
        for (int k = 1; k < NSRC; k++) begin
            if (src_sel == SW'(k))
                src = src_in[k*WIDTH +: WIDTH];
        end
    end

    assign sum  = {1'b0, acc_out} + {1'b0, src};
    assign diff = {1'b0, acc_out} - {1'b0, src};

    always_comb begin
        next_acc   = acc_out;
        next_carry = carry_out;
        case (op_e)
            NOP:  ;
            LOAD: begin
                next_acc   = src;
                next_carry = 1'b0;
            end
            ADD: begin
                next_carry = sum[WIDTH];
`ifdef ACC_SAT_EN
                next_acc   = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
                next_acc   = sum[WIDTH-1:0];
`endif
            end
            SUB: begin
                next_carry = diff[WIDTH];
`ifdef ACC_SAT_EN
                next_acc   = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
                next_acc   = diff[WIDTH-1:0];
`endif
            end
            SHL: begin
                next_carry = acc_out[WIDTH-1];
                next_acc   = {acc_out[WIDTH-2:0], 1'b0};
            end
            SHR: begin
                next_carry = acc_out[0];
                next_acc   = {1'b0, acc_out[WIDTH-1:1]};
            end
            PUSH: ;
            POP: begin
                if (!stack_empty)
                    next_acc = stack_top;
            end
        endcase
    end

    always_ff @(negedge CLK) begin
        if (!RST_N) begin
            acc_out   <= '0;
            carry_out <= 1'b0;
            zero_out  <= 1'b1;
        end else begin
            acc_out   <= next_acc;
            carry_out <= next_carry;
            zero_out  <= (next_acc == '0);
        end
    end

    acc_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_stack (
        .clk      (CLK),
        .rst_n    (RST_N),
        .push     (op_e == PUSH),
        .pop      (op_e == POP),
        .wdata    (acc_out),
        .top_data (stack_top),
        .depth    (depth_out),
        .full     (stack_full),
        .empty    (stack_empty),
        .err      (err_out)
    );

    // The full flag and the exported occupancy must always agree.
    full_matches_depth: assert property (@(negedge CLK) stack_full == (depth_out == DW'(DEPTH)));
endmodule
